// File: rtl/systolic_pe_dbuf.sv
// Weight-stationary signed MAC PE with shadow/active weight double buffer, optional saturation, sticky overflow.
// Latency 1 cycle (a/acc/valid); no backpressure, valid_out is informational for the array downstream.
module systolic_pe_dbuf #(
  parameter int DATA_W   = 16,
  parameter int ACC_W    = 32,
  parameter int SATURATE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_weight,
  input  logic [DATA_W-1:0] weight_in,
  output logic [DATA_W-1:0] w_out,
  input  logic              swap_weight,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] a_in,
  input  logic [ACC_W-1:0]  acc_in,
  output logic [DATA_W-1:0] a_out,
  output logic [ACC_W-1:0]  acc_out,
  output logic              valid_out,
  input  logic              clear_ovf,
  output logic              ovf
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int EXT_W  = ACC_W + 1 - PROD_W;

  generate
    if (ACC_W < 2 * DATA_W) begin : g_bad_acc_w
      $error("systolic_pe_dbuf: ACC_W must be >= 2*DATA_W");
    end
  endgenerate

  logic [DATA_W-1:0] shadow_w;
  logic [DATA_W-1:0] active_w;
  logic [PROD_W-1:0] prod;
  logic [ACC_W:0]    sum;
  logic              sum_ovf;
  logic [ACC_W-1:0]  acc_next;

  assign w_out = shadow_w;

  always_comb begin
    prod     = $signed(a_in) * $signed(active_w);
    sum      = {{EXT_W{prod[PROD_W-1]}}, prod} + {acc_in[ACC_W-1], acc_in};
    // Out of range exactly when the extra sign bit disagrees with the ACC_W sign bit.
    sum_ovf  = sum[ACC_W] ^ sum[ACC_W-1];
    acc_next = sum[ACC_W-1:0];
    if ((SATURATE != 0) && sum_ovf) begin
      acc_next = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_w <= '0;
      active_w <= '0;
    end else begin
      if (load_weight) shadow_w <= weight_in;
      if (swap_weight) active_w <= shadow_w;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_out     <= '0;
      acc_out   <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= valid_in;
      if (valid_in) begin
        a_out   <= a_in;
        acc_out <= acc_next;
      end
    end
  end

  // Set has priority over clear so an overflow in the clearing cycle is not lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf <= 1'b0;
    end else if (valid_in && sum_ovf) begin
      ovf <= 1'b1;
    end else if (clear_ovf) begin
      ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_systolic_pe_dbuf.sv
// Directed self-checking bench: one saturating and one wrapping PE driven by the same stimulus.
module tb_systolic_pe_dbuf;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_weight;
  logic [15:0] weight_in;
  logic        swap_weight;
  logic        valid_in;
  logic [15:0] a_in;
  logic [31:0] acc_in;
  logic        clear_ovf;

  logic [15:0] s_w_out, s_a_out, w_w_out, w_a_out;
  logic [31:0] s_acc_out, w_acc_out;
  logic        s_valid_out, s_ovf, w_valid_out, w_ovf;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  systolic_pe_dbuf #(.DATA_W(16), .ACC_W(32), .SATURATE(1)) dut_sat (
    .clk(clk), .reset(reset), .load_weight(load_weight), .weight_in(weight_in),
    .w_out(s_w_out), .swap_weight(swap_weight), .valid_in(valid_in), .a_in(a_in),
    .acc_in(acc_in), .a_out(s_a_out), .acc_out(s_acc_out), .valid_out(s_valid_out),
    .clear_ovf(clear_ovf), .ovf(s_ovf)
  );

  systolic_pe_dbuf #(.DATA_W(16), .ACC_W(32), .SATURATE(0)) dut_wrap (
    .clk(clk), .reset(reset), .load_weight(load_weight), .weight_in(weight_in),
    .w_out(w_w_out), .swap_weight(swap_weight), .valid_in(valid_in), .a_in(a_in),
    .acc_in(acc_in), .a_out(w_a_out), .acc_out(w_acc_out), .valid_out(w_valid_out),
    .clear_ovf(clear_ovf), .ovf(w_ovf)
  );

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Advance one rising edge and land 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    load_weight = 1'b0;
    swap_weight = 1'b0;
    valid_in    = 1'b0;
    clear_ovf   = 1'b0;
  endtask

  task automatic set_active(input logic [15:0] w);
    idle();
    load_weight = 1'b1; weight_in = w;
    step();
    load_weight = 1'b0; swap_weight = 1'b1;
    step();
    swap_weight = 1'b0;
  endtask

  task automatic mac(input logic [15:0] a, input logic [31:0] acc);
    valid_in = 1'b1; a_in = a; acc_in = acc;
    step();
    valid_in = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    weight_in = '0; a_in = '0; acc_in = '0;
    #1;
    step();
    step();
    check("rst_w_out", 32'(s_w_out), 32'h0);
    check("rst_a_out", 32'(s_a_out), 32'h0);
    check("rst_acc_out", s_acc_out, 32'h0);
    check("rst_valid", 32'(s_valid_out), 32'h0);
    check("rst_ovf", 32'(s_ovf), 32'h0);
    reset = 1'b0;

    // Test 1: basic load, swap, MAC
    load_weight = 1'b1; weight_in = 16'd3;
    step();
    load_weight = 1'b0;
    check("t1_w_out", 32'(s_w_out), 32'd3);
    swap_weight = 1'b1;
    step();
    swap_weight = 1'b0;
    mac(16'd2, 32'd0);
    check("t1_acc", s_acc_out, 32'd6);
    check("t1_a_out", 32'(s_a_out), 32'd2);
    check("t1_valid", 32'(s_valid_out), 32'd1);
    step();
    check("t1_acc_hold", s_acc_out, 32'd6);
    check("t1_valid_low", 32'(s_valid_out), 32'd0);

    // Test 2: load next weight while computing with the current one
    load_weight = 1'b1; weight_in = 16'hFFFC;
    valid_in = 1'b1; a_in = 16'd5; acc_in = 32'd10;
    step();
    idle();
    check("t2_acc_old_w", s_acc_out, 32'd25);
    check("t2_w_out", 32'(s_w_out), 32'h0000FFFC);
    swap_weight = 1'b1;
    step();
    swap_weight = 1'b0;
    mac(16'd5, 32'd10);
    check("t2_acc_new_w", s_acc_out, 32'hFFFFFFF6);

    // Test 3: swap in the same cycle as a MAC uses the pre-swap weight
    set_active(16'd3);
    load_weight = 1'b1; weight_in = 16'd7;
    step();
    load_weight = 1'b0;
    swap_weight = 1'b1;
    mac(16'd1, 32'd0);
    swap_weight = 1'b0;
    check("t3_acc_pre_swap", s_acc_out, 32'd3);
    mac(16'd1, 32'd0);
    check("t3_acc_post_swap", s_acc_out, 32'd7);

    // Tests 4/5: positive overflow, saturate vs wrap
    check("t4_ovf_before", 32'(s_ovf), 32'd0);
    set_active(16'h7FFF);
    mac(16'h7FFF, 32'h7FFF0000);
    check("t4_sat_pos", s_acc_out, 32'h7FFFFFFF);
    check("t4_sat_ovf", 32'(s_ovf), 32'd1);
    check("t5_wrap_pos", w_acc_out, 32'hBFFE0001);
    check("t5_wrap_ovf", 32'(w_ovf), 32'd1);
    clear_ovf = 1'b1;
    step();
    clear_ovf = 1'b0;
    check("t4_ovf_cleared", 32'(s_ovf), 32'd0);
    check("t5_ovf_cleared", 32'(w_ovf), 32'd0);

    // Negative overflow
    set_active(16'h8000);
    mac(16'h7FFF, 32'h80000000);
    check("t4_sat_neg", s_acc_out, 32'h80000000);
    check("t4_sat_neg_ovf", 32'(s_ovf), 32'd1);
    check("t5_wrap_neg", w_acc_out, 32'h40008000);

    // Clear coinciding with an overflowing MAC: set wins
    clear_ovf = 1'b1;
    mac(16'h7FFF, 32'h80000000);
    clear_ovf = 1'b0;
    check("t5_set_wins_sat", 32'(s_ovf), 32'd1);
    check("t5_set_wins_wrap", 32'(w_ovf), 32'd1);

    // Test 6: async reset between edges
    set_active(16'd3);
    mac(16'd2, 32'd0);
    check("t6_acc_pre_rst", s_acc_out, 32'd6);
    #2;
    reset = 1'b1;
    #1;
    check("t6_rst_acc", s_acc_out, 32'h0);
    check("t6_rst_a_out", 32'(s_a_out), 32'h0);
    check("t6_rst_w_out", 32'(s_w_out), 32'h0);
    check("t6_rst_valid", 32'(s_valid_out), 32'h0);
    check("t6_rst_ovf", 32'(s_ovf), 32'h0);
    check("t6_rst_wrap_ovf", 32'(w_ovf), 32'h0);
    step();
    check("t6_rst_hold_acc", s_acc_out, 32'h0);
    reset = 1'b0;
    mac(16'd9, 32'd4);
    check("t6_acc_after_rst", s_acc_out, 32'd4);
    check("t6_a_after_rst", 32'(s_a_out), 32'd9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
